feature_fifo_loader: RTL and testbench

//  Write-side source stage of the async-FIFO memory path. Captures a burst of

---
 rtl/mem_path_pkg.sv | 16 +
 rtl/feature_fifo_loader_if.sv | 33 +++
 rtl/loader_regfile.sv | 31 +++
 rtl/feature_fifo_loader.sv | 105 ++++++++++
 tb/tb_feature_fifo_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_path_pkg.sv
// Shared definitions for the async-FIFO memory path.
//  - default byte width / feature store geometry
//  - loader FSM state encoding
package mem_path_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } ld_state_e;

endpackage

// File: rtl/feature_fifo_loader_if.sv
// Host byte bus + FIFO write port + status of the feature FIFO loader.
//  master : host/FIFO side (drives wr_en, wr_data, clr, start, abort, fifo_wfull)
//  slave  : loader side (drives fifo_winc, fifo_wdata, busy, done, count, ovf, sum)
interface feature_fifo_loader_if
  import mem_path_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic                     wr_en;
  logic [DATA_W-1:0]        wr_data;
  logic                     clr;
  logic                     start;
  logic                     abort;
  logic                     fifo_wfull;
  logic                     fifo_winc;
  logic [DATA_W-1:0]        fifo_wdata;
  logic                     busy;
  logic                     done;
  logic [ADDR_W:0]          count;
  logic                     ovf;
  logic [DATA_W+ADDR_W-1:0] sum;

  modport master (
    output wr_en, wr_data, clr, start, abort, fifo_wfull,
    input  fifo_winc, fifo_wdata, busy, done, count, ovf, sum
  );

  modport slave (
    input  wr_en, wr_data, clr, start, abort, fifo_wfull,
    output fifo_winc, fifo_wdata, busy, done, count, ovf, sum
  );
endinterface

// File: rtl/loader_regfile.sv
// Feature store: DEPTH x DATA_W, synchronous write, asynchronous read.
//  clk    : write clock
//  we     : write enable
//  waddr  : write address
//  wdata  : write data
//  raddr  : read address (stream pointer)
//  rdata  : read data, combinational from raddr
// Contents are not reset.
module loader_regfile
  import mem_path_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/feature_fifo_loader.sv
// Write-side source stage of the async-FIFO memory path. Bytes from the host
// bus are captured into a local feature store; a start rising edge streams
// them in write order into the FIFO write port, stalling on fifo_wfull.
//  clk, rst_n : write-domain clock, async active-low reset
//  bus        : slave side of feature_fifo_loader_if (host bus, FIFO port,
//               busy/done/count/ovf/sum status)
// Interface instance parameters must match DATA_W/ADDR_W here.
module feature_fifo_loader
  import mem_path_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  feature_fifo_loader_if.slave bus
);

  localparam int              SUM_W = DATA_W + ADDR_W;
  localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  ld_state_e         state;
  logic              start_q;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] rptr;
  logic              ovf;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] rd_data;

  logic start_edge, store_we, push, last;

  assign start_edge = bus.start & ~start_q;
  // abort and clr both block the store write
  assign store_we   = (state == IDLE) & ~bus.abort & ~bus.clr & bus.wr_en & (count != FULL);
  assign push       = (state == STREAM) & ~bus.fifo_wfull;
  assign last       = ({1'b0, rptr} == (count - ONE));

  loader_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk   (clk),
    .we    (store_we),
    .waddr (count[ADDR_W-1:0]),
    .wdata (bus.wr_data),
    .raddr (rptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      count   <= '0;
      rptr    <= '0;
      ovf     <= 1'b0;
      sum     <= '0;
    end else begin
      start_q <= bus.start;
      if (bus.abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.clr) begin
              count <= '0;
              ovf   <= 1'b0;
            end else begin
              if (bus.wr_en) begin
                if (count == FULL) ovf <= 1'b1;
                else               count <= count + ONE;
              end
              if (start_edge) begin
                sum   <= '0;
                rptr  <= '0;
                state <= (count != '0) ? STREAM : DONE;
              end
            end
          end
          STREAM: begin
            if (push) begin
              rptr <= rptr + 1'b1;
              sum  <= sum + SUM_W'(rd_data);
              if (last) state <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.fifo_winc  = push;
  assign bus.fifo_wdata = rd_data;
  assign bus.busy       = (state == STREAM);
  assign bus.done       = (state == DONE);
  assign bus.count      = count;
  assign bus.ovf        = ovf;
  assign bus.sum        = sum;

endmodule

// File: tb/tb_feature_fifo_loader.sv
module tb_feature_fifo_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  feature_fifo_loader_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  feature_fifo_loader #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: store contents as a plain list of bytes
  logic [7:0] store[$];
  bit         ref_ovf = 1'b0;

  // scoreboard queues
  logic [7:0] exp_q[$];
  int         exp_sum_q[$];
  int         exp_n_q[$];
  logic [7:0] seen[$];

  logic [7:0] load_list[16] = '{8'd4, 8'd14, 8'd24, 8'd42, 8'd141, 8'd243, 8'd41, 8'd134,
                                8'd204, 8'd124, 8'd104, 8'd24, 8'd34, 8'd74, 8'd84, 8'd95};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pops expectations whenever the DUT pushes or signals done
  logic [7:0] mon_e;
  int         mon_n, mon_s;
  bit         prev_winc = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.fifo_winc) begin
        chk("winc_while_full", bus.fifo_wfull, 0);
        chk("push_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("push_data", bus.fifo_wdata, mon_e);
        end
        seen.push_back(bus.fifo_wdata);
      end
      if (bus.done) begin
        chk("done_expected", exp_sum_q.size() > 0, 1);
        if (exp_sum_q.size() > 0) begin
          mon_n = exp_n_q.pop_front();
          mon_s = exp_sum_q.pop_front();
          chk("done_sum", bus.sum, mon_s);
          chk("bytes_left_at_done", exp_q.size(), 0);
          chk("done_busy_low", bus.busy, 0);
          if (mon_n > 0) chk("done_after_last_push", prev_winc, 1);
        end
      end
      prev_winc = bus.fifo_winc;
    end else begin
      prev_winc = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (store.size() < 16) store.push_back(b);
    else                   ref_ovf = 1'b1;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic clr_store();
    tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    store.delete();
    ref_ovf = 1'b0;
  endtask

  task automatic load_spec_list();
    for (int i = 0; i < 16; i++) wr(load_list[i]);
  endtask

  task automatic chk_store(input string name);
    @(negedge clk);
    chk({name, "_count"}, bus.count, store.size());
    chk({name, "_ovf"}, bus.ovf, ref_ovf);
  endtask

  // Issue a start and run until done (or abort). wfull is forced high for
  // stream cycles stall_lo..stall_hi, plus randomly with rand_pct percent.
  // Stream cycle k=1 is the first cycle after the start edge is sampled.
  task automatic run_stream(input int stall_lo, input int stall_hi, input int rand_pct,
                            input int abort_at, output int k_done);
    int s;
    s = 0;
    foreach (store[i]) begin
      s += store[i];
      exp_q.push_back(store[i]);
    end
    exp_sum_q.push_back(s % 4096);
    exp_n_q.push_back(store.size());
    seen.delete();
    k_done = -1;
    tick();
    bus.start = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      bus.start      = 1'b0;
      bus.fifo_wfull = (k >= stall_lo && k <= stall_hi) || ($urandom_range(99) < rand_pct);
      bus.abort      = (k == abort_at);
      @(negedge clk);
      if (bus.done) begin
        k_done = k;
        break;
      end
      if (abort_at > 0 && k == abort_at + 1) begin
        chk("abort_busy", bus.busy, 0);
        chk("abort_winc", bus.fifo_winc, 0);
        chk("abort_pushes", seen.size(), abort_at);
        chk("abort_count_kept", bus.count, store.size());
        exp_q.delete();
        exp_sum_q.delete();
        exp_n_q.delete();
        break;
      end
    end
    bus.fifo_wfull = 1'b0;
    bus.abort      = 1'b0;
    if (abort_at == 0) chk("done_seen", k_done > 0, 1);
  endtask

  int         k1, k2, kx, n;
  logic [7:0] seq1[$];

  initial begin
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    bus.clr        = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.fifo_wfull = 1'b0;

    // reset state
    #2;
    chk("rst_winc", bus.fifo_winc, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_sum", bus.sum, 0);
    tick();
    rst_n = 1'b1;

    // 1: full load, no backpressure
    load_spec_list();
    chk_store("t1");
    run_stream(0, -1, 0, 0, k1);
    chk("t1_done_cycle", k1, 17);
    chk("t1_beats", seen.size(), 16);
    seq1 = seen;
    @(negedge clk);
    chk("t1_sum", bus.sum, 12'h56A);
    chk("t1_count", bus.count, 16);

    // 2: same load, stall stream cycles 3..7
    run_stream(3, 7, 0, 0, k2);
    chk("t2_done_delay", k2 - k1, 5);
    chk("t2_beats", seen.size(), seq1.size());
    for (int i = 0; i < 16 && i < seen.size(); i++) chk("t2_seq", seen[i], seq1[i]);

    // 3: overflow write, stream still ends in 95, then clr
    wr(8'd65);
    chk_store("t3");
    run_stream(0, -1, 0, 0, kx);
    chk("t3_last", seen.size() > 0 ? seen[seen.size()-1] : 8'hxx, 8'd95);
    clr_store();
    chk_store("t3_clr");

    // 4: empty stream
    run_stream(0, -1, 0, 0, kx);
    chk("t4_done_cycle", kx, 1);
    chk("t4_no_push", seen.size(), 0);
    @(negedge clk);
    chk("t4_sum", bus.sum, 0);

    // 5: abort after 5 pushes, then full restream
    load_spec_list();
    run_stream(0, -1, 0, 5, kx);
    run_stream(0, -1, 0, 0, kx);
    chk("t5_done_cycle", kx, 17);
    chk("t5_first", seen.size() > 0 ? seen[0] : 8'hxx, 8'd4);

    // 6: reset mid-stream
    exp_q.delete();
    foreach (store[i]) exp_q.push_back(store[i]);
    tick();
    bus.start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      bus.start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_winc", bus.fifo_winc, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_count", bus.count, 0);
    chk("t6_sum", bus.sum, 0);
    exp_q.delete();
    store.delete();
    ref_ovf = 1'b0;
    tick();
    rst_n = 1'b1;
    run_stream(0, -1, 0, 0, kx);
    chk("t6_restart_done", kx, 1);
    chk("t6_restart_no_push", seen.size(), 0);

    // randomized bursts with random backpressure
    for (int r = 0; r < 8; r++) begin
      clr_store();
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) wr(8'($urandom));
      chk_store("rand");
      run_stream(0, -1, 35, 0, kx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
